// File: rtl/ct_arb_pkg.sv
// ct_arb_pkg: shared widths, defaults and state encoding for the ciphertext arbiter
package ct_arb_pkg;
    localparam int NUM_REQ_DEF = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam logic [7:0] BURST_MAX_DEF = 8'd255;
    typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/ct_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first requester at or after ptr wins
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx
);
    // scan from farthest to nearest so the requester closest to ptr is assigned last
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                win = '0;
                win[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/ct_arbiter.sv
// ct_arbiter: round-robin / burst-lock arbiter sharing one ciphertext RAM between cores
module ct_arbiter
    import ct_arb_pkg::*;
#(
    parameter int         NUM_REQ   = NUM_REQ_DEF,
    parameter logic [7:0] BURST_MAX = BURST_MAX_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           lock,
    input  logic [NUM_REQ-1:0][AW-1:0]   addr,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           rvalid,
    output logic [NUM_REQ-1:0][DW-1:0]   rddata,
    output logic [AW-1:0]                ct_addr,
    input  logic [DW-1:0]                ct_rddata
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    state_t state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, win_idx, g_idx;
    logic [7:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0][DW-1:0] data_q;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req(req),
        .ptr(ptr_q),
        .win(win),
        .idx(win_idx)
    );

    // next state and grant; grant is killed combinationally while reset is high
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        g_idx   = win_idx;
        if (state_q == IDLE) begin
            gnt = win;
            if (|win) begin
                ptr_d = inc(win_idx);
                if (lock[win_idx] && BURST_MAX != 8'd1) begin
                    state_d = BURST;
                    owner_d = win_idx;
                    cnt_d   = 8'd1;
                end
            end
        end else begin
            g_idx = owner_q;
            if (req[owner_q]) begin
                gnt[owner_q] = 1'b1;
                cnt_d = cnt_q + 8'd1;
            end
            if (!lock[owner_q] || (req[owner_q] && cnt_q + 8'd1 == BURST_MAX)) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        end
        if (rst) gnt = '0;
    end

    assign ct_addr = |gnt ? addr[g_idx] : addr_q;

    // returned byte is visible in the rvalid cycle, then held until the next one
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) rddata[i] = rvalid[i] ? ct_rddata : data_q[i];
    end

    // state, pointer, held address and read-return registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rvalid  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= ct_addr;
            rvalid  <= gnt;
            for (int i = 0; i < NUM_REQ; i++) if (rvalid[i]) data_q[i] <= ct_rddata;
        end
    end
endmodule

// File: tb/tb_ct_arbiter.sv
// tb_ct_arbiter: directed and randomized checks of ct_arbiter against a behavioural model
module tb_ct_arbiter;
    localparam int N = 2;
    localparam int BM = 4;
    logic clk = 0, rst = 1;
    logic [N-1:0] req = '0, lock = '0, gnt, rvalid;
    logic [N-1:0][7:0] addr = '0, rddata;
    logic [7:0] ct_addr, ct_rddata = '0;
    logic [7:0] mem [256];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    // registered-output RAM, one cycle of latency
    always @(posedge clk) ct_rddata <= mem[ct_addr];

    ct_arbiter #(.NUM_REQ(N), .BURST_MAX(8'(BM))) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr),
        .gnt(gnt), .rvalid(rvalid), .rddata(rddata),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req = '0; lock = '0; addr = '0;
        next();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req = 2'b11; lock = 2'b11; addr[0] = 8'h11;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        next();
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
        checks++; if (ct_addr !== 8'h00) begin errors++; $display("FAIL reset_ct_addr got=%h exp=00", ct_addr); end
        checks++; if (rddata !== 16'h0000) begin errors++; $display("FAIL reset_rddata got=%h exp=0000", rddata); end
        rst = 0; req = '0; lock = '0;
    endtask

    task automatic test_single();
        do_reset();
        req = 2'b01; addr[0] = 8'h05;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
        checks++; if (ct_addr !== 8'h05) begin errors++; $display("FAIL single_addr got=%h exp=05", ct_addr); end
        next();
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid got=%b exp=01", rvalid); end
        checks++; if (rddata[0] !== 8'h33) begin errors++; $display("FAIL single_rddata got=%h exp=33", rddata[0]); end
        next();
        @(negedge clk);
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL single_rvalid_end got=%b exp=00", rvalid); end
        checks++; if (rddata[0] !== 8'h33) begin errors++; $display("FAIL single_rddata_hold got=%h exp=33", rddata[0]); end
        checks++; if (ct_addr !== 8'h05) begin errors++; $display("FAIL single_addr_hold got=%h exp=05", ct_addr); end
        next();
    endtask

    task automatic test_alternate();
        logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        req = 2'b11; addr[0] = 8'h10; addr[1] = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (gnt !== seq[i]) begin errors++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", i, gnt, seq[i]); end
            checks++; if (rvalid !== (i == 0 ? 2'b00 : seq[i-1])) begin errors++; $display("FAIL alt_rvalid[%0d] got=%b", i, rvalid); end
            next();
        end
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL alt_rvalid_last got=%b exp=10", rvalid); end
        checks++; if (rddata[0] !== mem[8'h10]) begin errors++; $display("FAIL alt_rddata0 got=%h exp=%h", rddata[0], mem[8'h10]); end
        checks++; if (rddata[1] !== mem[8'h20]) begin errors++; $display("FAIL alt_rddata1 got=%h exp=%h", rddata[1], mem[8'h20]); end
        next();
    endtask

    task automatic test_lock();
        logic [1:0] rq [6] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10};
        logic [1:0] lk [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic [1:0] eg [6] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = rq[i]; lock = lk[i];
            @(negedge clk);
            checks++; if (gnt !== eg[i]) begin errors++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", i, gnt, eg[i]); end
            next();
        end
    endtask

    task automatic test_burst_max();
        logic [1:0] eg [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        do_reset();
        req = 2'b11; lock = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (gnt !== eg[i]) begin errors++; $display("FAIL bmax_gnt[%0d] got=%b exp=%b", i, gnt, eg[i]); end
            next();
        end
    endtask

    task automatic test_reset_burst();
        do_reset();
        req = 2'b11; lock = 2'b01;
        next();
        rst = 1;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstb_gnt got=%b exp=00", gnt); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rstb_rvalid got=%b exp=00", rvalid); end
        next();
        rst = 0; lock = 2'b00;
        @(negedge clk);
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rstb_rvalid_after got=%b exp=00", rvalid); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstb_gnt_after got=%b exp=01", gnt); end
        next();
    endtask

    task automatic test_random();
        bit m_burst = 0;
        int m_owner = 0, m_cnt = 0, m_ptr = 0, g;
        logic [7:0] m_addr = 8'h00;
        logic [N-1:0] m_rv = '0, exp_gnt;
        logic [7:0] exp_addr;
        logic [7:0] m_held [N] = '{8'h00, 8'h00};
        do_reset();
        for (int c = 0; c < 500; c++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) lock[i] = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) addr[i] = 8'($urandom);
            @(negedge clk);
            g = -1;
            if (!m_burst) begin
                for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end else if (req[m_owner]) g = m_owner;
            exp_gnt = '0;
            if (g >= 0) exp_gnt[g] = 1'b1;
            exp_addr = (g >= 0) ? addr[g] : m_addr;
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
            checks++; if (ct_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, ct_addr, exp_addr); end
            checks++; if (rvalid !== m_rv) begin errors++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, rvalid, m_rv); end
            for (int i = 0; i < N; i++) begin
                if (m_rv[i]) m_held[i] = mem[m_addr];
                checks++; if (rddata[i] !== m_held[i]) begin errors++; $display("FAIL rnd_rddata%0d c=%0d got=%h exp=%h", i, c, rddata[i], m_held[i]); end
            end
            m_rv = exp_gnt;
            m_addr = exp_addr;
            if (!m_burst) begin
                if (g >= 0) begin
                    m_ptr = (g + 1) % N;
                    if (lock[g]) begin m_burst = 1; m_owner = g; m_cnt = 1; end
                end
            end else begin
                if (g >= 0) m_cnt++;
                if (!lock[m_owner] || m_cnt == BM) m_burst = 0;
            end
            next();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 8'h56);
        mem[5] = 8'h33;
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_burst_max();
        test_reset_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ct_arbiter.md
CT_ARBITER -- requirements
Module: ct_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of crack-core requesters sharing the ciphertext memory.
REQ-002 Parameter BURST_MAX, default 8'd255, maximum consecutive grants one locked owner holds before forced release.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester read request; held high until granted.
REQ-006 lock  input  NUM_REQ  per-requester burst-lock request, sampled with req.
REQ-007 addr  input  NUM_REQ x 8  per-requester ciphertext address; stable while req high.
REQ-008 gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req.
REQ-009 rvalid  output  NUM_REQ  read data valid for requester, one cycle after its gnt.
REQ-010 rddata  output  NUM_REQ x 8  per-requester read data; holds last returned byte.
REQ-011 ct_addr  output  8  shared memory address.
REQ-012 ct_rddata  input  8  shared memory data, registered-output RAM, 1-cycle latency.

Function
REQ-013 At most one gnt bit SHALL be high per cycle; gnt[i] only when req[i] high.
REQ-014 ct_addr SHALL equal addr of the granted requester in the grant cycle; otherwise hold previous value.
REQ-015 rvalid[i] SHALL be high exactly in cycle N+1 after gnt[i] in cycle N; rddata[i] SHALL capture ct_rddata then and hold until next rvalid[i].
REQ-016 States: IDLE, BURST; BURST carries owner index and 8-bit burst counter.
REQ-017 IDLE: any req -> round-robin winner granted; pointer starts at requester 0 after reset.
REQ-018 After a grant to i in IDLE, requester (i+1) mod NUM_REQ SHALL have highest priority next.
REQ-019 IDLE -> BURST when the granted requester also has lock high; owner = winner, counter = 1.
REQ-020 BURST: only owner granted (when req[owner] high); other requests stall, gnt low for them.
REQ-021 BURST -> IDLE in the cycle after lock[owner] is low; a grant in that cycle still issued if req[owner] high.
REQ-022 BURST counter increments per owner grant; on reaching BURST_MAX SHALL force BURST -> IDLE with priority moved to next requester, regardless of lock.
REQ-023 Owner req low with lock high: stay BURST, no grant, counter unchanged.
REQ-024 Simultaneous req from all in IDLE, no lock: grants alternate every cycle, no starvation.
REQ-025 Single requester active: granted every cycle, full throughput.

Reset
REQ-026 rst asserted (any time) SHALL immediately force: state IDLE, gnt 0, rvalid 0, rddata 0, ct_addr 0, pointer 0, counter 0.
REQ-027 A read granted in the cycle rst asserts SHALL produce no rvalid.
REQ-028 Outputs SHALL leave reset values only on first rising edge after rst deasserts.

Structure
REQ-029 Package ct_arb_pkg SHALL hold NUM_REQ default, address/data widths (8), BURST_MAX default, state enum.
REQ-030 One sub-module rr_pick SHALL implement combinational round-robin selection (req vector, pointer -> one-hot winner).

Verification
REQ-031 req=2'b01, addr[0]=8'h05, mem[5]=8'h33 -> gnt=01, ct_addr=05; next cycle rvalid=01, rddata[0]=33.
REQ-032 req=2'b11 held 4 cycles, no lock -> gnt sequence 01,10,01,10; rvalid follows one cycle later.
REQ-033 req0+lock0 high 3 grants, req1 high throughout -> gnt 01 x3, req1 stalled; lock0 low -> req1 granted next cycle.
REQ-034 BURST_MAX=4, req0+lock0 held, req1 high -> 4 grants to 0 then forced release, gnt=10.
REQ-035 rst pulsed during BURST with pending read -> rvalid stays 0, state IDLE, next req=2'b11 grants requester 0.
REQ-036 Two crack cores plus ct_arbiter on 256-byte ciphertext (first byte 8'h56) -> key 24'h000001 found, every returned byte matches memory.
